xlr8_seq_ctrl: RTL and testbench

Sequencer for the 8x8 systolic-array matrix multiplier (`xlr8`). On `start` it:
- clears the PE accumulators;
- reads matrix A and matrix B (8-bit elements, row-major) from the operand memory into eight A-row FIFOs and eight B-column FIFOs;
- pops the FIFOs with diagonal skew into the array edges;
- waits a fixed drain time, then raises `done`.

It sits between the operand memory, the edge FIFOs and the PE grid, and replaces ad-hoc start/done wiring at the `xlr8` top.

---
 rtl/xlr8_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_xlr8_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_seq_ctrl.sv
// Start/done sequencer for the xlr8 systolic array: loads A rows and B columns
// from operand memory into the edge FIFOs, streams them with diagonal skew, then drains.
module xlr8_seq_ctrl #(
    parameter int N         = 8,
    parameter int AW        = 10,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] addr_mtxA,
    input  logic [AW-1:0] addr_mtxB,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] fifo_wdata,
    output logic [N-1:0]  a_wr_en,
    output logic [N-1:0]  b_wr_en,
    output logic [N-1:0]  a_rd_en,
    output logic [N-1:0]  b_rd_en,
    input  logic          all_full,
    input  logic          all_empty,
    output logic          pe_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    localparam int          IW         = $clog2(N);
    localparam logic [15:0] LAST_IDX   = 16'(N * N - 1);
    localparam logic [15:0] LAST_S     = 16'(2 * N - 2);
    localparam logic [15:0] LAST_DRAIN = 16'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT_FULL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [AW-1:0]     base_a_q, base_a_d;
    logic [AW-1:0]     base_b_q, base_b_d;
    logic              err_q, err_d;
    logic              wr_vld_q, wr_vld_d;
    logic              wr_b_q, wr_b_d;
    logic [2*IW-1:0]   wr_idx_q, wr_idx_d;

    // cnt_q is the element index in the load phases, the skew step s in STREAM
    // and the drain counter in DRAIN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        err_d     = err_q;
        wr_vld_d  = 1'b0;
        wr_b_d    = 1'b0;
        wr_idx_d  = cnt_q[2*IW-1:0];
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        pe_clr    = 1'b0;
        a_rd_en   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_a_d = addr_mtxA;
                    base_b_d = addr_mtxB;
                    state_d  = S_CLR;
                end
            end
            S_CLR: begin
                pe_clr  = 1'b1;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_a_q + AW'(cnt_q);
                wr_vld_d  = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOAD_B: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_b_q + AW'(cnt_q);
                wr_vld_d  = 1'b1;
                wr_b_d    = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_FULL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_FULL: begin
                if (all_full) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // FIFO i pops on steps i..i+N-1, giving the diagonal edge skew.
                for (int i = 0; i < N; i++) begin
                    a_rd_en[i] = (cnt_q >= 16'(i)) && (cnt_q <= 16'(i + N - 1));
                end
                if (cnt_q == LAST_S) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if ((cnt_q == 16'd0) && !all_empty) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory data arrives the cycle after the read, alongside the delayed index.
    always_comb begin
        fifo_wdata = '0;
        a_wr_en    = '0;
        b_wr_en    = '0;
        if (wr_vld_q) begin
            fifo_wdata = mem_rdata;
            if (wr_b_q) begin
                b_wr_en[wr_idx_q[IW-1:0]] = 1'b1;
            end else begin
                a_wr_en[wr_idx_q[2*IW-1:IW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            err_q    <= 1'b0;
            wr_vld_q <= 1'b0;
            wr_b_q   <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            err_q    <= err_d;
            wr_vld_q <= wr_vld_d;
            wr_b_q   <= wr_b_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    assign b_rd_en   = a_rd_en;
    assign err       = err_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_xlr8_seq_ctrl.sv
// Directed bench for xlr8_seq_ctrl: cycle-exact check of every output over
// nominal, wrapped-address, stalled, error, level-start and mid-run-reset runs.
module tb_xlr8_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] addr_mtxA;
    logic [9:0] addr_mtxB;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] fifo_wdata;
    logic [7:0] a_wr_en;
    logic [7:0] b_wr_en;
    logic [7:0] a_rd_en;
    logic [7:0] b_rd_en;
    logic       all_full;
    logic       all_empty;
    logic       pe_clr;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state_dbg;

    logic [7:0] mem [0:1023];
    int         n_vec;
    int         n_err;
    logic       exp_err;

    xlr8_seq_ctrl #(.N(8), .AW(10), .DW(8), .DRAIN_CYC(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr_mtxA  (addr_mtxA),
        .addr_mtxB  (addr_mtxB),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .fifo_wdata (fifo_wdata),
        .a_wr_en    (a_wr_en),
        .b_wr_en    (b_wr_en),
        .a_rd_en    (a_rd_en),
        .b_rd_en    (b_rd_en),
        .all_full   (all_full),
        .all_empty  (all_empty),
        .pe_clr     (pe_clr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // Clock and operand memory with one-cycle read latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'h5a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Layout: pe_clr busy done err rd_en addr[10] wdata[8] a_wr b_wr a_rd b_rd
    function automatic logic [63:0] obs_vec(input bit mask_wd);
        logic [7:0] wd;
        wd = mask_wd ? 8'h00 : fifo_wdata;
        return {9'b0, pe_clr, busy, done, err, mem_rd_en, mem_addr, wd,
                a_wr_en, b_wr_en, a_rd_en, b_rd_en};
    endfunction

    function automatic logic [63:0] exp_vec(input int c, input logic [9:0] ba,
                                            input logic [9:0] bb, input int st,
                                            input bit bad, input logic perr);
        logic       pe, bs, dn, er, rd;
        logic [9:0] ad;
        logic [7:0] wd, aw, bw, rm;
        int         t, s;
        t  = 132 + st;
        pe = (c == 1);
        bs = (c >= 1) && (c < t + 24);
        dn = (c >= t + 24);
        er = (c <= 1) ? perr : (bad && (c >= t + 16));
        rd = (c >= 2) && (c <= 129);
        ad = 10'd0;
        if (c >= 2 && c <= 65) ad = ba + 10'(c - 2);
        else if (c >= 66 && c <= 129) ad = bb + 10'(c - 66);
        aw = 8'h00;
        bw = 8'h00;
        wd = 8'h00;
        if (c >= 3 && c <= 66) begin
            aw = 8'h01 << ((c - 3) / 8);
            wd = mem[ba + 10'(c - 3)];
        end else if (c >= 67 && c <= 130) begin
            bw = 8'h01 << ((c - 67) % 8);
            wd = mem[bb + 10'(c - 67)];
        end
        rm = 8'h00;
        s  = c - t;
        if (s >= 0 && s <= 14) begin
            for (int i = 0; i < 8; i++) begin
                if (i <= s && s <= i + 7) rm[i] = 1'b1;
            end
        end
        return {9'b0, pe, bs, dn, er, rd, ad, wd, aw, bw, rm, rm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    // One run from its IDLE cycle 0; stops after the done cycle or after abort_at.
    task automatic run(input int id, input logic [9:0] ba, input logic [9:0] bb,
                       input int st, input bit bad, input bit hold, input int abort_at);
        logic        perr;
        logic [63:0] e;
        int          t, last;
        perr = exp_err;
        t    = 132 + st;
        last = (abort_at >= 0) ? abort_at : t + 24;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #2;
            start     = (c == 0) || hold;
            addr_mtxA = (c == 0) ? ba : ~ba;
            addr_mtxB = (c == 0) ? bb : ~bb;
            all_full  = (c == t - 1);
            all_empty = (c < t + 15) ? 1'b0 : ((c == t + 15) ? !bad : 1'b1);
            #2;
            e = exp_vec(c, ba, bb, st, bad, perr);
            chk($sformatf("run%0d c%0d", id, c), obs_vec(e[31:16] == 16'h0), e);
        end
        if (abort_at < 0) exp_err = bad;
    endtask

    task automatic chk_done(input string tag);
        logic [63:0] e;
        e     = 64'h0;
        e[52] = 1'b1;
        e[51] = exp_err;
        chk(tag, obs_vec(1'b1), e);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_err   = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        addr_mtxA = 10'd0;
        addr_mtxB = 10'd0;
        all_full  = 1'b0;
        all_empty = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            if (a < 64) mem[a] = ((a / 8) == (a % 8)) ? 8'd1 : 8'd0;
            else if (a < 128) mem[a] = 8'(a - 64);
            else mem[a] = 8'((a * 37 + 11) & 255);
        end

        // Reset for one cycle: every output low.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #2;
        chk("reset", obs_vec(1'b0), 64'h0);

        // Nominal run with start held high through DONE.
        run(1, 10'd0, 10'd64, 0, 1'b0, 1'b1, -1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            start = 1'b1;
            #2;
            chk($sformatf("hold%0d", k), obs_vec(1'b1), {9'b0, 1'b0, 1'b0, 1'b1, exp_err, 51'h0});
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        #2;
        chk_done("drop");

        // Re-start after the drop, with base A wrapping past 1023 and base B near the top.
        run(2, 10'd1020, 10'd1000, 0, 1'b0, 1'b0, -1);

        // all_full held low for 20 extra cycles.
        run(3, 10'd300, 10'd500, 20, 1'b0, 1'b0, -1);

        // all_empty low at STREAM exit sets err.
        run(4, 10'd0, 10'd64, 0, 1'b1, 1'b0, -1);

        // err cleared by CLR, then reset during LOAD_B.
        run(5, 10'd10, 10'd900, 0, 1'b0, 1'b0, 80);
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst     = 1'b1;
        start   = 1'b0;
        exp_err = 1'b0;
        #2;
        chk("midrst", obs_vec(1'b0), 64'h0);

        // Fresh run after the abort keeps the nominal timing.
        run(6, 10'd0, 10'd64, 0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
